tawas_regfile_mt: RTL and testbench

- Parametrised barrel-thread register file for the Tawas core.
- Holds THREADS independent banks of REGS x DW registers.
- Read and write ports address banks by a per-port pipeline lag relative to the current SLICE.
- Adds an outstanding-AXI-load scoreboard per bank. It flags read hazards on registers still awaiting AXI data and throttles new AXI load requests per thread.

---
 rtl/tawas_rf_pkg.sv | 27 ++
 rtl/tawas_rf_scoreboard.sv | 81 ++++++++
 rtl/tawas_regfile_mt.sv | 150 +++++++++++++++
 tb/tb_tawas_regfile_mt.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tawas_rf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tawas_rf_pkg : write-source priority encoding and bank-index helper  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package tawas_rf_pkg;

    // Lower value = higher priority when two writes target the same register.
    typedef enum logic [2:0] {
        WR_LS_LOAD  = 3'd0,
        WR_LS_PTR   = 3'd1,
        WR_AU_RC    = 3'd2,
        WR_RF_IMM   = 3'd3,
        WR_PC_STORE = 3'd4,
        WR_AXI_LOAD = 3'd5
    } wr_src_e;

    localparam int NUM_WR_SRC = 6;

    function automatic int unsigned bank_wrap(input int unsigned slice,
                                              input int unsigned lag,
                                              input int unsigned threads);
        return (slice + threads - (lag % threads)) % threads;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tawas_rf_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tawas_rf_scoreboard : per-bank outstanding AXI load tracking          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tawas_rf_scoreboard #(
    parameter int THREADS   = 4,
    parameter int REGS      = 8,
    parameter int MAX_OUTST = 4,
    localparam int TW = $clog2(THREADS),
    localparam int RW = $clog2(REGS),
    localparam int CW = $clog2(MAX_OUTST + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [TW-1:0] rd_bank_i,
    input  logic [RW-1:0] ra_sel_i,
    input  logic [RW-1:0] rb_sel_i,
    input  logic [RW-1:0] ptr_sel_i,
    input  logic [RW-1:0] st_sel_i,
    input  logic          req_vld_i,
    input  logic [TW-1:0] req_bank_i,
    input  logic [RW-1:0] req_sel_i,
    input  logic          ld_vld_i,
    input  logic [TW-1:0] ld_bank_i,
    input  logic [RW-1:0] ld_sel_i,
    output logic          ld_wr_o,
    output logic          full_o,
    output logic          hazard_o,
    output logic          err_o
);

    logic [REGS-1:0] pend_q [THREADS];
    logic [REGS-1:0] pend_d [THREADS];
    logic [CW-1:0]   cnt_q  [THREADS];
    logic [CW-1:0]   cnt_d  [THREADS];
    logic            err_q;
    logic            err_d;
    logic            ret_ok;
    logic            req_ok;
    logic            same_thr;
    logic            same_bit;

    always_comb begin
        ret_ok   = ld_vld_i && pend_q[ld_bank_i][ld_sel_i];
        same_thr = ret_ok && (req_bank_i == ld_bank_i);
        same_bit = same_thr && (req_sel_i == ld_sel_i);
        // A return in the same cycle frees its slot, so a request may reuse it.
        req_ok   = req_vld_i
                   && (!pend_q[req_bank_i][req_sel_i] || same_bit)
                   && ((cnt_q[req_bank_i] != CW'(MAX_OUTST)) || same_thr);
        err_d    = (req_vld_i && !req_ok) || (ld_vld_i && !ret_ok);

        pend_d = pend_q;
        cnt_d  = cnt_q;
        if (ret_ok) pend_d[ld_bank_i][ld_sel_i] = 1'b0;
        if (req_ok) pend_d[req_bank_i][req_sel_i] = 1'b1;
        if (req_ok && !same_thr) cnt_d[req_bank_i] = cnt_q[req_bank_i] + CW'(1);
        if (ret_ok && !(req_ok && same_thr)) cnt_d[ld_bank_i] = cnt_q[ld_bank_i] - CW'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend_q <= '{default: '0};
            cnt_q  <= '{default: '0};
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign ld_wr_o  = ret_ok;
    assign full_o   = (cnt_q[rd_bank_i] == CW'(MAX_OUTST));
    assign hazard_o = pend_q[rd_bank_i][ra_sel_i]  | pend_q[rd_bank_i][rb_sel_i]
                    | pend_q[rd_bank_i][ptr_sel_i] | pend_q[rd_bank_i][st_sel_i];
    assign err_o    = err_q;

endmodule
`default_nettype wire

// File: rtl/tawas_regfile_mt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tawas_regfile_mt : barrel-thread register file with AXI scoreboard    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tawas_regfile_mt
    import tawas_rf_pkg::*;
#(
    parameter int THREADS   = 4,
    parameter int REGS      = 8,
    parameter int DW        = 32,
    parameter int PCW       = 24,
    parameter int PC_REG    = 6,
    parameter int RD_LAG    = 1,
    parameter int IMM_LAG   = 1,
    parameter int AU_LAG    = 3,
    parameter int PTR_LAG   = 2,
    parameter int LD_LAG    = 0,
    parameter int MAX_OUTST = 4,
    localparam int TW = $clog2(THREADS),
    localparam int RW = $clog2(REGS)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [TW-1:0] SLICE,
    input  logic          PC_STORE,
    input  logic [PCW-1:0] PC,
    output logic [PCW-1:0] PC_RTN,
    input  logic          RF_IMM_VLD,
    input  logic [RW-1:0] RF_IMM_SEL,
    input  logic [DW-1:0] RF_IMM,
    input  logic [RW-1:0] AU_RA_SEL,
    input  logic [RW-1:0] AU_RB_SEL,
    input  logic [RW-1:0] LS_PTR_SEL,
    input  logic [RW-1:0] LS_STORE_SEL,
    output logic [DW-1:0] AU_RA,
    output logic [DW-1:0] AU_RB,
    output logic [DW-1:0] LS_PTR,
    output logic [DW-1:0] LS_STORE,
    input  logic          AU_RC_VLD,
    input  logic [RW-1:0] AU_RC_SEL,
    input  logic [DW-1:0] AU_RC,
    input  logic          LS_PTR_UPD_VLD,
    input  logic [RW-1:0] LS_PTR_UPD_SEL,
    input  logic [DW-1:0] LS_PTR_UPD,
    input  logic          LS_LOAD_VLD,
    input  logic [RW-1:0] LS_LOAD_SEL,
    input  logic [DW-1:0] LS_LOAD,
    input  logic          AXI_REQ_VLD,
    input  logic [TW-1:0] AXI_REQ_SLICE,
    input  logic [RW-1:0] AXI_REQ_SEL,
    output logic          AXI_REQ_FULL,
    input  logic          AXI_LOAD_VLD,
    input  logic [TW-1:0] AXI_LOAD_SLICE,
    input  logic [RW-1:0] AXI_LOAD_SEL,
    input  logic [DW-1:0] AXI_LOAD,
    output logic          RD_HAZARD,
    output logic          AXI_ERR
);

    logic [DW-1:0]         rf_q [THREADS][REGS];
    logic [TW-1:0]         rd_bank;
    logic [TW-1:0]         imm_bank;
    logic [TW-1:0]         au_bank;
    logic [TW-1:0]         ptr_bank;
    logic [TW-1:0]         ld_bank;
    logic                  axi_wr;
    logic [NUM_WR_SRC-1:0] wr_vld;
    logic [TW-1:0]         wr_bank [NUM_WR_SRC];
    logic [RW-1:0]         wr_sel  [NUM_WR_SRC];
    logic [DW-1:0]         wr_data [NUM_WR_SRC];

    assign rd_bank  = TW'(bank_wrap(32'(SLICE), RD_LAG,  THREADS));
    assign imm_bank = TW'(bank_wrap(32'(SLICE), IMM_LAG, THREADS));
    assign au_bank  = TW'(bank_wrap(32'(SLICE), AU_LAG,  THREADS));
    assign ptr_bank = TW'(bank_wrap(32'(SLICE), PTR_LAG, THREADS));
    assign ld_bank  = TW'(bank_wrap(32'(SLICE), LD_LAG,  THREADS));

    always_comb begin
        wr_vld = '0;
        wr_vld[WR_LS_LOAD]   = LS_LOAD_VLD;
        wr_bank[WR_LS_LOAD]  = ld_bank;
        wr_sel[WR_LS_LOAD]   = LS_LOAD_SEL;
        wr_data[WR_LS_LOAD]  = LS_LOAD;
        wr_vld[WR_LS_PTR]    = LS_PTR_UPD_VLD;
        wr_bank[WR_LS_PTR]   = ptr_bank;
        wr_sel[WR_LS_PTR]    = LS_PTR_UPD_SEL;
        wr_data[WR_LS_PTR]   = LS_PTR_UPD;
        wr_vld[WR_AU_RC]     = AU_RC_VLD;
        wr_bank[WR_AU_RC]    = au_bank;
        wr_sel[WR_AU_RC]     = AU_RC_SEL;
        wr_data[WR_AU_RC]    = AU_RC;
        wr_vld[WR_RF_IMM]    = RF_IMM_VLD;
        wr_bank[WR_RF_IMM]   = imm_bank;
        wr_sel[WR_RF_IMM]    = RF_IMM_SEL;
        wr_data[WR_RF_IMM]   = RF_IMM;
        wr_vld[WR_PC_STORE]  = PC_STORE;
        wr_bank[WR_PC_STORE] = imm_bank;
        wr_sel[WR_PC_STORE]  = RW'(PC_REG);
        wr_data[WR_PC_STORE] = DW'(PC);
        // Returns to non-pending registers are rejected, so gate on the scoreboard.
        wr_vld[WR_AXI_LOAD]  = axi_wr;
        wr_bank[WR_AXI_LOAD] = AXI_LOAD_SLICE;
        wr_sel[WR_AXI_LOAD]  = AXI_LOAD_SEL;
        wr_data[WR_AXI_LOAD] = AXI_LOAD;
    end

    // Lowest priority first; a later non-blocking write to the same entry wins.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rf_q <= '{default: '{default: '0}};
        end else begin
            for (int s = NUM_WR_SRC - 1; s >= 0; s--) begin
                if (wr_vld[s]) rf_q[wr_bank[s]][wr_sel[s]] <= wr_data[s];
            end
        end
    end

    assign AU_RA    = rf_q[rd_bank][AU_RA_SEL];
    assign AU_RB    = rf_q[rd_bank][AU_RB_SEL];
    assign LS_PTR   = rf_q[rd_bank][LS_PTR_SEL];
    assign LS_STORE = rf_q[rd_bank][LS_STORE_SEL];
    assign PC_RTN   = rf_q[rd_bank][PC_REG][PCW-1:0];

    tawas_rf_scoreboard #(
        .THREADS   (THREADS),
        .REGS      (REGS),
        .MAX_OUTST (MAX_OUTST)
    ) u_scoreboard (
        .CLK        (CLK),
        .RST        (RST),
        .rd_bank_i  (rd_bank),
        .ra_sel_i   (AU_RA_SEL),
        .rb_sel_i   (AU_RB_SEL),
        .ptr_sel_i  (LS_PTR_SEL),
        .st_sel_i   (LS_STORE_SEL),
        .req_vld_i  (AXI_REQ_VLD),
        .req_bank_i (AXI_REQ_SLICE),
        .req_sel_i  (AXI_REQ_SEL),
        .ld_vld_i   (AXI_LOAD_VLD),
        .ld_bank_i  (AXI_LOAD_SLICE),
        .ld_sel_i   (AXI_LOAD_SEL),
        .ld_wr_o    (axi_wr),
        .full_o     (AXI_REQ_FULL),
        .hazard_o   (RD_HAZARD),
        .err_o      (AXI_ERR)
    );

endmodule
`default_nettype wire

// File: tb/tb_tawas_regfile_mt.sv
`default_nettype none
// Directed self-checking bench for tawas_regfile_mt (default parameters).
module tb_tawas_regfile_mt;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  SLICE;
    logic        PC_STORE;
    logic [23:0] PC;
    logic [23:0] PC_RTN;
    logic        RF_IMM_VLD;
    logic [2:0]  RF_IMM_SEL;
    logic [31:0] RF_IMM;
    logic [2:0]  AU_RA_SEL, AU_RB_SEL, LS_PTR_SEL, LS_STORE_SEL;
    logic [31:0] AU_RA, AU_RB, LS_PTR, LS_STORE;
    logic        AU_RC_VLD;
    logic [2:0]  AU_RC_SEL;
    logic [31:0] AU_RC;
    logic        LS_PTR_UPD_VLD;
    logic [2:0]  LS_PTR_UPD_SEL;
    logic [31:0] LS_PTR_UPD;
    logic        LS_LOAD_VLD;
    logic [2:0]  LS_LOAD_SEL;
    logic [31:0] LS_LOAD;
    logic        AXI_REQ_VLD;
    logic [1:0]  AXI_REQ_SLICE;
    logic [2:0]  AXI_REQ_SEL;
    logic        AXI_REQ_FULL;
    logic        AXI_LOAD_VLD;
    logic [1:0]  AXI_LOAD_SLICE;
    logic [2:0]  AXI_LOAD_SEL;
    logic [31:0] AXI_LOAD;
    logic        RD_HAZARD;
    logic        AXI_ERR;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    tawas_regfile_mt dut (
        .CLK(CLK), .RST(RST), .SLICE(SLICE),
        .PC_STORE(PC_STORE), .PC(PC), .PC_RTN(PC_RTN),
        .RF_IMM_VLD(RF_IMM_VLD), .RF_IMM_SEL(RF_IMM_SEL), .RF_IMM(RF_IMM),
        .AU_RA_SEL(AU_RA_SEL), .AU_RB_SEL(AU_RB_SEL),
        .LS_PTR_SEL(LS_PTR_SEL), .LS_STORE_SEL(LS_STORE_SEL),
        .AU_RA(AU_RA), .AU_RB(AU_RB), .LS_PTR(LS_PTR), .LS_STORE(LS_STORE),
        .AU_RC_VLD(AU_RC_VLD), .AU_RC_SEL(AU_RC_SEL), .AU_RC(AU_RC),
        .LS_PTR_UPD_VLD(LS_PTR_UPD_VLD), .LS_PTR_UPD_SEL(LS_PTR_UPD_SEL),
        .LS_PTR_UPD(LS_PTR_UPD),
        .LS_LOAD_VLD(LS_LOAD_VLD), .LS_LOAD_SEL(LS_LOAD_SEL), .LS_LOAD(LS_LOAD),
        .AXI_REQ_VLD(AXI_REQ_VLD), .AXI_REQ_SLICE(AXI_REQ_SLICE),
        .AXI_REQ_SEL(AXI_REQ_SEL), .AXI_REQ_FULL(AXI_REQ_FULL),
        .AXI_LOAD_VLD(AXI_LOAD_VLD), .AXI_LOAD_SLICE(AXI_LOAD_SLICE),
        .AXI_LOAD_SEL(AXI_LOAD_SEL), .AXI_LOAD(AXI_LOAD),
        .RD_HAZARD(RD_HAZARD), .AXI_ERR(AXI_ERR)
    );

    task automatic idle();
        PC_STORE = 0; PC = '0;
        RF_IMM_VLD = 0; RF_IMM_SEL = '0; RF_IMM = '0;
        AU_RA_SEL = '0; AU_RB_SEL = '0; LS_PTR_SEL = '0; LS_STORE_SEL = '0;
        AU_RC_VLD = 0; AU_RC_SEL = '0; AU_RC = '0;
        LS_PTR_UPD_VLD = 0; LS_PTR_UPD_SEL = '0; LS_PTR_UPD = '0;
        LS_LOAD_VLD = 0; LS_LOAD_SEL = '0; LS_LOAD = '0;
        AXI_REQ_VLD = 0; AXI_REQ_SLICE = '0; AXI_REQ_SEL = '0;
        AXI_LOAD_VLD = 0; AXI_LOAD_SLICE = '0; AXI_LOAD_SEL = '0; AXI_LOAD = '0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (AU_RA !== 32'h0) begin failures++; $display("FAIL rst_au_ra: got %h expected %h", AU_RA, 32'h0); end
        checks++; if (PC_RTN !== 24'h0) begin failures++; $display("FAIL rst_pc_rtn: got %h expected %h", PC_RTN, 24'h0); end
        checks++; if (RD_HAZARD !== 1'b0 || AXI_REQ_FULL !== 1'b0 || AXI_ERR !== 1'b0) begin
            failures++; $display("FAIL rst_flags: got hz=%b full=%b err=%b expected 0 0 0", RD_HAZARD, AXI_REQ_FULL, AXI_ERR); end
        RST = 0;
        tick();
        SLICE = 2; LS_LOAD_VLD = 1; LS_LOAD_SEL = 3; LS_LOAD = 32'hDEADBEEF;
        AXI_REQ_VLD = 1; AXI_REQ_SLICE = 2; AXI_REQ_SEL = 3;
        tick();
        idle(); SLICE = 3; AU_RA_SEL = 3;
        #1;
        checks++; if (AU_RA !== 32'hDEADBEEF) begin failures++; $display("FAIL pre_rst_data: got %h expected %h", AU_RA, 32'hDEADBEEF); end
        checks++; if (RD_HAZARD !== 1'b1) begin failures++; $display("FAIL pre_rst_hazard: got %b expected 1", RD_HAZARD); end
        #2 RST = 1;
        #1;
        checks++; if (AU_RA !== 32'h0) begin failures++; $display("FAIL midrst_data: got %h expected %h", AU_RA, 32'h0); end
        checks++; if (RD_HAZARD !== 1'b0 || AXI_REQ_FULL !== 1'b0) begin
            failures++; $display("FAIL midrst_flags: got hz=%b full=%b expected 0 0", RD_HAZARD, AXI_REQ_FULL); end
        tick();
        RST = 0;
        idle();
        tick();
    endtask

    task automatic test_lag();
        SLICE = 0; AU_RC_VLD = 1; AU_RC_SEL = 5; AU_RC = 32'h11;
        tick();
        idle(); SLICE = 2; AU_RA_SEL = 5;
        #1;
        checks++; if (AU_RA !== 32'h11) begin failures++; $display("FAIL lag_au_rc: got %h expected %h", AU_RA, 32'h11); end
        SLICE = 1;
        #1;
        checks++; if (AU_RA !== 32'h0) begin failures++; $display("FAIL lag_other_bank: got %h expected %h", AU_RA, 32'h0); end
        tick();
        SLICE = 0; RF_IMM_VLD = 1; RF_IMM_SEL = 7; RF_IMM = 32'h77;
        tick();
        idle(); SLICE = 3; LS_PTR_UPD_VLD = 1; LS_PTR_UPD_SEL = 2; LS_PTR_UPD = 32'h22;
        tick();
        idle(); SLICE = 0; LS_PTR_SEL = 7;
        #1;
        checks++; if (LS_PTR !== 32'h77) begin failures++; $display("FAIL lag_imm_wrap: got %h expected %h", LS_PTR, 32'h77); end
        SLICE = 2; AU_RB_SEL = 2;
        #1;
        checks++; if (AU_RB !== 32'h22) begin failures++; $display("FAIL lag_ptr_upd: got %h expected %h", AU_RB, 32'h22); end
        tick();
        idle(); SLICE = 1; PC_STORE = 1; PC = 24'hABCDE1;
        tick();
        idle(); SLICE = 1; LS_STORE_SEL = 6;
        #1;
        checks++; if (PC_RTN !== 24'hABCDE1) begin failures++; $display("FAIL pc_rtn: got %h expected %h", PC_RTN, 24'hABCDE1); end
        checks++; if (LS_STORE !== 32'h00ABCDE1) begin failures++; $display("FAIL pc_zext: got %h expected %h", LS_STORE, 32'h00ABCDE1); end
        tick();
    endtask

    task automatic test_collision();
        idle(); SLICE = 1; RF_IMM_VLD = 1; RF_IMM_SEL = 6; RF_IMM = 32'h55;
        PC_STORE = 1; PC = 24'h000123;
        tick();
        idle(); SLICE = 1; LS_STORE_SEL = 6;
        #1;
        checks++; if (LS_STORE !== 32'h55) begin failures++; $display("FAIL imm_over_pc: got %h expected %h", LS_STORE, 32'h55); end
        tick();
        idle(); AXI_REQ_VLD = 1; AXI_REQ_SLICE = 1; AXI_REQ_SEL = 2;
        tick();
        idle(); SLICE = 2; AU_RA_SEL = 2;
        #1;
        checks++; if (RD_HAZARD !== 1'b1) begin failures++; $display("FAIL coll_pending: got %b expected 1", RD_HAZARD); end
        SLICE = 1; LS_LOAD_VLD = 1; LS_LOAD_SEL = 2; LS_LOAD = 32'hAA;
        AXI_LOAD_VLD = 1; AXI_LOAD_SLICE = 1; AXI_LOAD_SEL = 2; AXI_LOAD = 32'hBB;
        tick();
        idle(); SLICE = 2; AU_RA_SEL = 2;
        #1;
        checks++; if (AU_RA !== 32'hAA) begin failures++; $display("FAIL coll_data: got %h expected %h", AU_RA, 32'hAA); end
        checks++; if (RD_HAZARD !== 1'b0 || AXI_ERR !== 1'b0) begin
            failures++; $display("FAIL coll_clear: got hz=%b err=%b expected 0 0", RD_HAZARD, AXI_ERR); end
        for (int i = 0; i < 3; i++) begin
            AXI_REQ_VLD = 1; AXI_REQ_SLICE = 1; AXI_REQ_SEL = 3'(i);
            tick();
        end
        idle(); SLICE = 2;
        #1;
        checks++; if (AXI_REQ_FULL !== 1'b0) begin failures++; $display("FAIL coll_cnt_dec: got full=%b expected 0", AXI_REQ_FULL); end
        AXI_REQ_VLD = 1; AXI_REQ_SLICE = 1; AXI_REQ_SEL = 3;
        tick();
        idle(); SLICE = 2;
        #1;
        checks++; if (AXI_REQ_FULL !== 1'b1) begin failures++; $display("FAIL coll_full4: got full=%b expected 1", AXI_REQ_FULL); end
        for (int i = 0; i < 4; i++) begin
            AXI_LOAD_VLD = 1; AXI_LOAD_SLICE = 1; AXI_LOAD_SEL = 3'(i); AXI_LOAD = 32'(i);
            tick();
        end
        idle(); SLICE = 2;
        #1;
        checks++; if (AXI_REQ_FULL !== 1'b0) begin failures++; $display("FAIL coll_drain: got full=%b expected 0", AXI_REQ_FULL); end
        tick();
    endtask

    task automatic test_scoreboard();
        idle(); AXI_REQ_VLD = 1; AXI_REQ_SLICE = 3; AXI_REQ_SEL = 4;
        tick();
        idle(); SLICE = 0; AU_RB_SEL = 4;
        #1;
        checks++; if (RD_HAZARD !== 1'b1) begin failures++; $display("FAIL sb_hazard_rb: got %b expected 1", RD_HAZARD); end
        AU_RB_SEL = 0; LS_STORE_SEL = 4;
        #1;
        checks++; if (RD_HAZARD !== 1'b1) begin failures++; $display("FAIL sb_hazard_st: got %b expected 1", RD_HAZARD); end
        LS_STORE_SEL = 0;
        #1;
        checks++; if (RD_HAZARD !== 1'b0) begin failures++; $display("FAIL sb_no_hazard: got %b expected 0", RD_HAZARD); end
        AXI_LOAD_VLD = 1; AXI_LOAD_SLICE = 3; AXI_LOAD_SEL = 4; AXI_LOAD = 32'h1234;
        tick();
        idle(); SLICE = 0; AU_RB_SEL = 4;
        #1;
        checks++; if (RD_HAZARD !== 1'b0 || AXI_ERR !== 1'b0) begin
            failures++; $display("FAIL sb_return: got hz=%b err=%b expected 0 0", RD_HAZARD, AXI_ERR); end
        checks++; if (AU_RB !== 32'h1234) begin failures++; $display("FAIL sb_data: got %h expected %h", AU_RB, 32'h1234); end
        tick();
    endtask

    task automatic test_throttle();
        for (int i = 0; i < 4; i++) begin
            idle(); AXI_REQ_VLD = 1; AXI_REQ_SLICE = 0; AXI_REQ_SEL = 3'(i);
            tick();
        end
        idle(); SLICE = 1;
        #1;
        checks++; if (AXI_REQ_FULL !== 1'b1) begin failures++; $display("FAIL thr_full: got %b expected 1", AXI_REQ_FULL); end
        SLICE = 2;
        #1;
        checks++; if (AXI_REQ_FULL !== 1'b0) begin failures++; $display("FAIL thr_other_bank: got %b expected 0", AXI_REQ_FULL); end
        AXI_REQ_VLD = 1; AXI_REQ_SLICE = 0; AXI_REQ_SEL = 4;
        tick();
        checks++; if (AXI_ERR !== 1'b1) begin failures++; $display("FAIL thr_err: got %b expected 1", AXI_ERR); end
        idle();
        tick();
        checks++; if (AXI_ERR !== 1'b0) begin failures++; $display("FAIL thr_err_pulse: got %b expected 0", AXI_ERR); end
        SLICE = 1; AU_RA_SEL = 4; AU_RB_SEL = 4; LS_PTR_SEL = 4; LS_STORE_SEL = 4;
        #1;
        checks++; if (RD_HAZARD !== 1'b0) begin failures++; $display("FAIL thr_r4_pending: got %b expected 0", RD_HAZARD); end
        AU_RA_SEL = 0;
        #1;
        checks++; if (RD_HAZARD !== 1'b1) begin failures++; $display("FAIL thr_r0_pending: got %b expected 1", RD_HAZARD); end
        idle(); AXI_LOAD_VLD = 1; AXI_LOAD_SLICE = 0; AXI_LOAD_SEL = 5; AXI_LOAD = 32'h99;
        tick();
        checks++; if (AXI_ERR !== 1'b1) begin failures++; $display("FAIL ret_nonpend_err: got %b expected 1", AXI_ERR); end
        idle(); SLICE = 1; AU_RA_SEL = 5;
        #1;
        checks++; if (AU_RA !== 32'h0) begin failures++; $display("FAIL ret_nonpend_data: got %h expected %h", AU_RA, 32'h0); end
        for (int i = 0; i < 4; i++) begin
            idle(); AXI_LOAD_VLD = 1; AXI_LOAD_SLICE = 0; AXI_LOAD_SEL = 3'(i); AXI_LOAD = 32'h100 + 32'(i);
            tick();
        end
        idle(); SLICE = 1;
        #1;
        checks++; if (AXI_REQ_FULL !== 1'b0 || AXI_ERR !== 1'b0) begin
            failures++; $display("FAIL thr_drain: got full=%b err=%b expected 0 0", AXI_REQ_FULL, AXI_ERR); end
        AXI_REQ_VLD = 1; AXI_REQ_SLICE = 0; AXI_REQ_SEL = 0;
        tick();
        tick();
        checks++; if (AXI_ERR !== 1'b1) begin failures++; $display("FAIL dup_req_err: got %b expected 1", AXI_ERR); end
        idle(); AXI_LOAD_VLD = 1; AXI_LOAD_SLICE = 0; AXI_LOAD_SEL = 0; AXI_LOAD = 32'h5;
        tick();
        idle();
        tick();
    endtask

    task automatic test_same_cycle();
        idle(); AXI_REQ_VLD = 1; AXI_REQ_SLICE = 2; AXI_REQ_SEL = 1;
        tick();
        AXI_LOAD_VLD = 1; AXI_LOAD_SLICE = 2; AXI_LOAD_SEL = 1; AXI_LOAD = 32'h5A;
        tick();
        checks++; if (AXI_ERR !== 1'b0) begin failures++; $display("FAIL same_err: got %b expected 0", AXI_ERR); end
        idle(); SLICE = 3; AU_RA_SEL = 1;
        #1;
        checks++; if (RD_HAZARD !== 1'b1) begin failures++; $display("FAIL same_pending: got %b expected 1", RD_HAZARD); end
        checks++; if (AU_RA !== 32'h5A) begin failures++; $display("FAIL same_data: got %h expected %h", AU_RA, 32'h5A); end
        for (int i = 2; i < 4; i++) begin
            idle(); AXI_REQ_VLD = 1; AXI_REQ_SLICE = 2; AXI_REQ_SEL = 3'(i);
            tick();
        end
        idle(); SLICE = 3;
        #1;
        checks++; if (AXI_REQ_FULL !== 1'b0) begin failures++; $display("FAIL same_cnt3: got %b expected 0", AXI_REQ_FULL); end
        AXI_REQ_VLD = 1; AXI_REQ_SLICE = 2; AXI_REQ_SEL = 4;
        tick();
        idle(); SLICE = 3;
        #1;
        checks++; if (AXI_REQ_FULL !== 1'b1) begin failures++; $display("FAIL same_cnt4: got %b expected 1", AXI_REQ_FULL); end
        tick();
    endtask

    initial begin
        idle();
        SLICE = 0;
        RST = 1;
        repeat (2) @(posedge CLK);
        #1;
        test_reset();
        test_lag();
        test_collision();
        test_scoreboard();
        test_throttle();
        test_same_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
